// File: rtl/logic_exec_stage.sv
// logic_exec_stage: two-register bitwise logic execution stage with
// valid/ready handshakes on both sides.
//   S1 captures the operation (op, A, B) on an input handshake.
//   S2 captures the result (Y, zero flag) when S1 advances.
//   op_count counts results accepted by downstream, wrapping at all-ones.
// Optional feature: define LOGIC_EXEC_PARITY_EN to add a registered
// 'parity' output (XOR-reduction of Y, loaded together with Y).
module logic_exec_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             zero,
`ifdef LOGIC_EXEC_PARITY_EN
  output logic             parity,
`endif
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  // Stage 1: captured operation
  logic             s1_valid;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  // Stage 2: captured result
  logic             s2_valid;
  logic [WIDTH-1:0] s2_y;
  logic             s2_zero;
`ifdef LOGIC_EXEC_PARITY_EN
  logic             s2_parity;
`endif

  // Goes high on the first edge after reset release; keeps in_ready low
  // throughout reset and for the edge that ends it.
  logic             ready_en;

  logic             in_hs;
  logic             out_hs;
  logic             s2_load;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] count_q;

  // Handshake and advance conditions
  assign out_hs   = s2_valid & out_ready;
  assign s2_load  = s1_valid & (~s2_valid | out_ready);
  assign in_ready = ready_en & (~s1_valid | s2_load);
  assign in_hs    = in_valid & in_ready;

  // Bitwise function of the operands held in S1
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    result = '0;
    unique case (s1_op)
      OP_AND: result = s1_a & s1_b;
      OP_OR:  result = s1_a | s1_b;
      OP_XOR: result = s1_a ^ s1_b;
      OP_NOR: result = ~(s1_a | s1_b);
    endcase
  end

  // Ready enable: asserted one edge after reset deasserts
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) ready_en <= 1'b0;
    else     ready_en <= 1'b1;
  end

  // Stage 1 occupancy and operand capture
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: operand/result registers are reset too, so Y reads 0 during
    // reset and no stale data is visible after an abort.
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_AND;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      if (in_hs) begin
        s1_valid <= 1'b1;
        s1_op    <= op_e'(op);
        s1_a     <= A;
        s1_b     <= B;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2 occupancy and result capture; holds while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_y      <= '0;
      s2_zero   <= 1'b0;
`ifdef LOGIC_EXEC_PARITY_EN
      s2_parity <= 1'b0;
`endif
    end else begin
      if (s2_load) begin
        s2_valid  <= 1'b1;
        s2_y      <= result;
        s2_zero   <= (result == '0);
`ifdef LOGIC_EXEC_PARITY_EN
        s2_parity <= ^result;
`endif
      end else if (out_hs) begin
        s2_valid <= 1'b0;
      end
    end
  end

  // Completed-operation counter, wraps naturally at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         count_q <= '0;
    else if (out_hs) count_q <= count_q + 1'b1;
  end

  assign out_valid = s2_valid;
  assign Y         = s2_y;
  assign zero      = s2_zero & s2_valid;
  assign op_count  = count_q;
`ifdef LOGIC_EXEC_PARITY_EN
  assign parity    = s2_parity;
`endif

endmodule

// File: tb/tb_logic_exec_stage.sv
// Directed testbench for logic_exec_stage: reset, streaming, all ops,
// zero flag, backpressure, counter wrap and mid-flight reset.
module tb_logic_exec_stage;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y;
  logic             zero;
`ifdef LOGIC_EXEC_PARITY_EN
  logic             parity;
`endif
  logic [CNT_W-1:0] op_count;

  int               n_vec;
  int               n_err;
  logic [CNT_W-1:0] exp_count;

  logic_exec_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Y        (Y),
    .zero     (zero),
`ifdef LOGIC_EXEC_PARITY_EN
    .parity   (parity),
`endif
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Advance one clock and settle past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] o,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    in_valid = v;
    op       = o;
    A        = a;
    B        = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 2'b00, '0, '0);
    out_ready = 1'b0;
    repeat (3) step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (Y !== '0) begin n_err++; $display("FAIL reset_y: got %h want 0", Y); end
    n_vec++; if (zero !== 1'b0) begin n_err++; $display("FAIL reset_zero: got %b want 0", zero); end
    n_vec++; if (op_count !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", op_count); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ready_before_edge: got %b want 0", in_ready); end
    step();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_release: got %b want 1", in_ready); end
    exp_count = '0;
  endtask

  task automatic test_xor_stream();
    out_ready = 1'b1;
    drive(1'b1, 2'b10, 32'h000000F0, 32'h000000FF);
    step();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL xor_in_ready: got %b want 1", in_ready); end
    drive(1'b1, 2'b10, 32'h0000000F, 32'h000000FF);
    step();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL xor_valid0: got %b want 1", out_valid); end
    n_vec++; if (Y !== 32'h0000000F) begin n_err++; $display("FAIL xor_y0: got %h want 0000000f", Y); end
    drive(1'b0, 2'b00, '0, '0);
    step();
    n_vec++; if (Y !== 32'h000000F0) begin n_err++; $display("FAIL xor_y1: got %h want 000000f0", Y); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL xor_valid1: got %b want 1", out_valid); end
    step();
    exp_count = exp_count + 2'd2;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL xor_drained: got %b want 0", out_valid); end
    n_vec++; if (op_count !== exp_count) begin n_err++; $display("FAIL xor_count: got %0d want %0d", op_count, exp_count); end
  endtask

  task automatic test_all_ops();
    logic [WIDTH-1:0] exp_y [4];
    exp_y[0] = 32'hFF000000;
    exp_y[1] = 32'hFFFFFF00;
    exp_y[2] = 32'h00FFFF00;
    exp_y[3] = 32'h000000FF;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (cyc < 4) drive(1'b1, 2'(cyc), 32'hFFFF0000, 32'hFF00FF00);
      else         drive(1'b0, 2'b00, '0, '0);
      step();
      if (cyc >= 1 && cyc <= 4) begin
        n_vec++; if (Y !== exp_y[cyc-1]) begin n_err++; $display("FAIL ops_y[%0d]: got %h want %h", cyc-1, Y, exp_y[cyc-1]); end
        n_vec++; if (out_valid !== 1'b1 || zero !== 1'b0) begin n_err++; $display("FAIL ops_flags[%0d]: got valid=%b zero=%b want valid=1 zero=0", cyc-1, out_valid, zero); end
      end
    end
    exp_count = exp_count + 3'd4;
    n_vec++; if (op_count !== exp_count) begin n_err++; $display("FAIL ops_count: got %0d want %0d", op_count, exp_count); end
  endtask

  task automatic test_zero();
    out_ready = 1'b1;
    drive(1'b1, 2'b10, 32'hAAAAAAAA, 32'hAAAAAAAA);
    step();
    drive(1'b0, 2'b00, '0, '0);
    step();
    n_vec++; if (Y !== '0) begin n_err++; $display("FAIL zero_y: got %h want 0", Y); end
    n_vec++; if (zero !== 1'b1) begin n_err++; $display("FAIL zero_flag: got %b want 1", zero); end
`ifdef LOGIC_EXEC_PARITY_EN
    n_vec++; if (parity !== 1'b0) begin n_err++; $display("FAIL zero_parity: got %b want 0", parity); end
`endif
    step();
    exp_count = exp_count + 1'b1;
    n_vec++; if (zero !== 1'b0) begin n_err++; $display("FAIL zero_unqualified: got %b want 0", zero); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 32'h12340000, 32'h00005678);   // OR  -> 12345678
    step();
    drive(1'b1, 2'b00, 32'hF0F0F0F0, 32'h0FF00FF0);   // AND -> 00F000F0
    step();
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    n_vec++; if (Y !== 32'h12345678 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_first: got y=%h valid=%b want 12345678 valid=1", Y, out_valid); end
`ifdef LOGIC_EXEC_PARITY_EN
    n_vec++; if (parity !== 1'b1) begin n_err++; $display("FAIL bp_parity: got %b want 1", parity); end
`endif
    drive(1'b1, 2'b10, 32'hDEADBEEF, 32'h00000000);   // must be ignored
    step();
    step();
    n_vec++; if (Y !== 32'h12345678 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold: got y=%h valid=%b want 12345678 valid=1", Y, out_valid); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_held: got %b want 0", in_ready); end
    drive(1'b1, 2'b11, 32'h00000000, 32'h00000000);   // NOR -> FFFFFFFF
    out_ready = 1'b1;
    step();
    n_vec++; if (Y !== 32'h00F000F0) begin n_err++; $display("FAIL bp_second: got %h want 00f000f0", Y); end
    drive(1'b0, 2'b00, '0, '0);
    step();
    n_vec++; if (Y !== 32'hFFFFFFFF || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_third: got y=%h valid=%b want ffffffff valid=1", Y, out_valid); end
    step();
    exp_count = exp_count + 2'd3;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %b want 0", out_valid); end
    n_vec++; if (op_count !== exp_count) begin n_err++; $display("FAIL bp_count: got %0d want %0d", op_count, exp_count); end
  endtask

  task automatic test_wrap_and_reset();
    int n;
    n = 65535 - int'(exp_count);
    out_ready = 1'b1;
    drive(1'b1, 2'b01, 32'h00000001, 32'h00000002);
    repeat (n) step();
    drive(1'b0, 2'b00, '0, '0);
    repeat (2) step();
    exp_count = exp_count + 16'(n);
    n_vec++; if (op_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preload: got %h want ffff", op_count); end
    drive(1'b1, 2'b00, 32'h00000001, 32'h00000001);
    step();
    drive(1'b0, 2'b00, '0, '0);
    repeat (2) step();
    n_vec++; if (op_count !== '0) begin n_err++; $display("FAIL wrap_to_zero: got %h want 0", op_count); end

    // Fill both stages, then reset mid-flight
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 32'h0000FFFF, 32'h00000000);
    step();
    drive(1'b1, 2'b10, 32'hFFFF0000, 32'h00000000);
    step();
    drive(1'b0, 2'b00, '0, '0);
    n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL full_state: got valid=%b ready=%b want 1/0", out_valid, in_ready); end
    rst = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0 || Y !== '0) begin n_err++; $display("FAIL async_reset: got valid=%b y=%h want 0/0", out_valid, Y); end
    out_ready = 1'b1;
    step();
    @(negedge clk);
    rst = 1'b0;
    step();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
    repeat (3) step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stale_result: got valid=%b y=%h want valid=0", out_valid, Y); end
    n_vec++; if (op_count !== '0) begin n_err++; $display("FAIL post_reset_count: got %0d want 0", op_count); end
    exp_count = '0;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    exp_count = '0;
    rst       = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 2'b00, '0, '0);
    test_reset();
    test_xor_stream();
    test_all_ops();
    test_zero();
    test_backpressure();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
